// File: rtl/instruction_fetch_pkg.sv
// FetchPackage: shared types and constants for the instruction fetch stage.
//   FetchState_t      : fetch control state (running or parked on a fault)
//   INSTRUCTION_BYTES : PC increment per sequential fetch
package FetchPackage;

    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_FAULT = 1'b1
    } FetchState_t;

    localparam logic [31:0] INSTRUCTION_BYTES = 32'd4;

endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner and IF/ID register with stall, flush and delay-slot redirects.
//   clk, rst (async, active-low)
//   stall, flush, redirectValid, redirectTarget : pipeline control from later stages
//   pcDataOutput     : instruction word from Memory at pcAddress
//   pcAddress        : PC register, no logic in between
//   instruction, instructionPC, instructionValid : IF/ID register
//   misalignedFault  : sticky, set when a misaligned target reaches the PC
module instruction_fetch
    import FetchPackage::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    input  logic [31:0] pcDataOutput,
    output logic [31:0] pcAddress,
    output logic [31:0] instruction,
    output logic [31:0] instructionPC,
    output logic        instructionValid,
    output logic        misalignedFault
);

    FetchState_t state, stateNext;
    logic [31:0] pc, pcNext, pendTarget, pendTargetNext;
    logic [31:0] instrReg, instrRegNext, instrPcReg, instrPcRegNext;
    logic        pendValid, pendValidNext, validReg, validRegNext, faultReg, faultRegNext;
    logic        haveTarget, badTarget;
    logic [31:0] target;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FETCH_RUN;
            pc         <= RESET_PC;
            pendValid  <= 1'b0;
            pendTarget <= 32'h0;
            instrReg   <= 32'h0;
            instrPcReg <= 32'h0;
            validReg   <= 1'b0;
            faultReg   <= 1'b0;
        end else begin
            state      <= stateNext;
            pc         <= pcNext;
            pendValid  <= pendValidNext;
            pendTarget <= pendTargetNext;
            instrReg   <= instrRegNext;
            instrPcReg <= instrPcRegNext;
            validReg   <= validRegNext;
            faultReg   <= faultRegNext;
        end
    end

    always_comb begin
        // A live redirect beats one parked during an earlier stall
        haveTarget     = redirectValid | pendValid;
        target         = redirectValid ? redirectTarget : pendTarget;
        badTarget      = haveTarget && (target[1:0] != 2'b00);
        stateNext      = state;
        pcNext         = pc;
        pendValidNext  = pendValid;
        pendTargetNext = pendTarget;
        instrRegNext   = instrReg;
        instrPcRegNext = instrPcReg;
        validRegNext   = validReg;
        faultRegNext   = faultReg;
        if (state == FETCH_FAULT) begin
            validRegNext = 1'b0;
        end else if (flush) begin
            validRegNext  = 1'b0;
            pendValidNext = 1'b0;
            if (badTarget) begin
                stateNext    = FETCH_FAULT;
                faultRegNext = 1'b1;
            end else if (haveTarget) begin
                pcNext = target;
            end
        end else if (stall) begin
            if (redirectValid) begin
                pendValidNext  = 1'b1;
                pendTargetNext = redirectTarget;
            end
        end else begin
            // The word latched here is the delay slot when a redirect applies
            instrRegNext   = pcDataOutput;
            instrPcRegNext = pc;
            validRegNext   = 1'b1;
            pendValidNext  = 1'b0;
            if (badTarget) begin
                stateNext    = FETCH_FAULT;
                faultRegNext = 1'b1;
            end else begin
                pcNext = haveTarget ? target : pc + INSTRUCTION_BYTES;
            end
        end
    end

    always_comb begin
        pcAddress        = pc;
        instruction      = instrReg;
        instructionPC    = instrPcReg;
        instructionValid = validReg;
        misalignedFault  = faultReg;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vector table, reset/wrap sequences and randomized run against a reference model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst, stall, flush, redirectValid;
    logic [31:0] redirectTarget, pcDataOutput, pcAddress, instruction, instructionPC;
    logic        instructionValid, misalignedFault;
    logic        wRst;
    logic [31:0] wData, wAddr, wInstr, wIpc;
    logic        wValid, wFault;
    logic [31:0] mem [64];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign pcDataOutput = mem[pcAddress[7:2]];
    assign wData        = mem[wAddr[7:2]];

    instruction_fetch dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirectValid(redirectValid), .redirectTarget(redirectTarget),
        .pcDataOutput(pcDataOutput), .pcAddress(pcAddress),
        .instruction(instruction), .instructionPC(instructionPC),
        .instructionValid(instructionValid), .misalignedFault(misalignedFault)
    );

    instruction_fetch #(.RESET_PC(32'hFFFFFFFC)) wrapDut (
        .clk(clk), .rst(wRst), .stall(1'b0), .flush(1'b0),
        .redirectValid(1'b0), .redirectTarget(32'h0),
        .pcDataOutput(wData), .pcAddress(wAddr),
        .instruction(wInstr), .instructionPC(wIpc),
        .instructionValid(wValid), .misalignedFault(wFault)
    );

    typedef struct {
        bit          s, f, rv;
        logic [31:0] tg;
        logic [31:0] eI, eP;
        bit          eV, eF;
        logic [31:0] eA;
    } Vec_t;

    Vec_t vecs [25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic [31:0] eI, input logic [31:0] eP,
                            input bit eV, input bit eF, input logic [31:0] eA);
        check({tag, ".instruction"}, instruction, eI);
        check({tag, ".instructionPC"}, instructionPC, eP);
        check({tag, ".valid"}, 32'(instructionValid), 32'(eV));
        check({tag, ".fault"}, 32'(misalignedFault), 32'(eF));
        check({tag, ".pcAddress"}, pcAddress, eA);
    endtask

    task automatic drive(input bit s, input bit f, input bit rv, input logic [31:0] tg);
        stall = s; flush = f; redirectValid = rv; redirectTarget = tg;
    endtask

    // Reference model state: pending redirects kept as a queue, newest at the back
    logic [31:0] mPc, mInstr, mIpc;
    bit          mValid, mFault;
    logic [31:0] pq [$];

    task automatic modelStep(input bit s, input bit f, input bit rv, input logic [31:0] tg);
        bit          have;
        logic [31:0] t;
        have = rv || pq.size() > 0;
        t    = rv ? tg : (pq.size() > 0 ? pq[$] : 32'h0);
        if (mFault) begin
            mValid = 0;
        end else if (f) begin
            mValid = 0;
            pq.delete();
            if (have && t % 4 != 0) mFault = 1;
            else if (have) mPc = t;
        end else if (s) begin
            if (rv) pq.push_back(tg);
        end else begin
            mInstr = mem[mPc[7:2]];
            mIpc   = mPc;
            mValid = 1;
            pq.delete();
            if (have && t % 4 != 0) mFault = 1;
            else mPc = have ? t : mPc + 32'd4;
        end
    endtask

    task automatic modelReset();
        mPc = 0; mInstr = 0; mIpc = 0; mValid = 0; mFault = 0;
        pq.delete();
    endtask

    initial begin
        vecs = '{
            '{0,0,0,32'h0,  32'd0,32'd0,  1,0,32'd4},
            '{0,0,0,32'h0,  32'd1,32'd4,  1,0,32'd8},
            '{1,0,0,32'h0,  32'd1,32'd4,  1,0,32'd8},
            '{1,0,0,32'h0,  32'd1,32'd4,  1,0,32'd8},
            '{1,0,0,32'h0,  32'd1,32'd4,  1,0,32'd8},
            '{0,0,0,32'h0,  32'd2,32'd8,  1,0,32'd12},
            '{0,0,1,32'd4,  32'd3,32'd12, 1,0,32'd4},
            '{0,0,0,32'h0,  32'd1,32'd4,  1,0,32'd8},
            '{1,0,1,32'd12, 32'd1,32'd4,  1,0,32'd8},
            '{1,0,1,32'd0,  32'd1,32'd4,  1,0,32'd8},
            '{0,0,0,32'h0,  32'd2,32'd8,  1,0,32'd0},
            '{0,0,0,32'h0,  32'd0,32'd0,  1,0,32'd4},
            '{0,1,1,32'd16, 32'd0,32'd0,  0,0,32'd16},
            '{0,0,0,32'h0,  32'd4,32'd16, 1,0,32'd20},
            '{0,1,0,32'h0,  32'd4,32'd16, 0,0,32'd20},
            '{0,0,0,32'h0,  32'd5,32'd20, 1,0,32'd24},
            '{1,0,1,32'd8,  32'd5,32'd20, 1,0,32'd24},
            '{0,1,0,32'h0,  32'd5,32'd20, 0,0,32'd8},
            '{0,0,0,32'h0,  32'd2,32'd8,  1,0,32'd12},
            '{1,1,1,32'd0,  32'd2,32'd8,  0,0,32'd0},
            '{0,0,0,32'h0,  32'd0,32'd0,  1,0,32'd4},
            '{0,0,1,32'd6,  32'd1,32'd4,  1,1,32'd4},
            '{0,0,0,32'h0,  32'd1,32'd4,  0,1,32'd4},
            '{0,1,1,32'd8,  32'd1,32'd4,  0,1,32'd4},
            '{1,0,1,32'd12, 32'd1,32'd4,  0,1,32'd4}
        };
        for (int i = 0; i < 64; i++) mem[i] = 32'(i);
        rst = 0; wRst = 0;
        drive(0, 0, 0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkAll("reset", 32'h0, 32'h0, 0, 0, 32'h0);
        check("wrap.resetPc", wAddr, 32'hFFFFFFFC);
        rst = 1; wRst = 1;

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].s, vecs[i].f, vecs[i].rv, vecs[i].tg);
            @(posedge clk);
            #1;
            checkAll($sformatf("vec%0d", i), vecs[i].eI, vecs[i].eP, vecs[i].eV, vecs[i].eF, vecs[i].eA);
            if (i == 0) begin
                check("wrap.pcAddress", wAddr, 32'h0);
                check("wrap.instructionPC", wIpc, 32'hFFFFFFFC);
                check("wrap.instruction", wInstr, 32'd63);
            end
        end

        // Asynchronous reset out of the fault state, released mid-cycle
        drive(0, 0, 0, 32'h0);
        rst = 0;
        #1;
        checkAll("asyncReset", 32'h0, 32'h0, 0, 0, 32'h0);
        #2 rst = 1;
        @(posedge clk);
        #1;
        checkAll("afterRelease", 32'h0, 32'h0, 1, 0, 32'd4);

        // Randomized run against the reference model
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        rst = 0;
        #2 rst = 1;
        modelReset();
        for (int n = 0, faultCycles = 0; n < 600; n++) begin
            bit          s, f, rv;
            logic [31:0] tg;
            s  = $urandom_range(0, 3) == 0;
            f  = $urandom_range(0, 7) == 0;
            rv = $urandom_range(0, 4) == 0;
            tg = (32'($urandom_range(0, 63)) << 2)
                 | ($urandom_range(0, 39) == 0 ? 32'($urandom_range(1, 3)) : 32'h0);
            drive(s, f, rv, tg);
            modelStep(s, f, rv, tg);
            @(posedge clk);
            #1;
            checkAll($sformatf("rand%0d", n), mInstr, mIpc, mValid, mFault, mPc);
            faultCycles = mFault ? faultCycles + 1 : 0;
            if (faultCycles > 4) begin
                rst = 0;
                #2 rst = 1;
                modelReset();
                faultCycles = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the CPU, directly downstream of `Memory`'s instruction port. It owns the program counter and drives `pcAddress`. It captures `pcDataOutput` into the IF/ID register one instruction per cycle. It also handles stall, flush and branch/jump redirects with MIPS delay-slot semantics.

## Interface
- `RESET_PC`, default 32'h0: PC value loaded on reset.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: reset, asynchronous and active-low.
- `stall  in  1`: hold the IF/ID register and PC.
- `flush  in  1`: squash the IF/ID register; overrides `stall`.
- `redirectValid  in  1`: a branch or jump is taken this cycle.
- `redirectTarget  in  32`: byte address of the new PC.
- `pcDataOutput  in  32`: instruction word from `Memory`, combinational on `pcAddress`.
- `pcAddress  out  32`: current PC, wired directly from the PC register.
- `instruction  out  32`: IF/ID instruction word.
- `instructionPC  out  32`: address `instruction` was fetched from.
- `instructionValid  out  1`: IF/ID holds a live instruction.
- `misalignedFault  out  1`: sticky; a redirect target had bits [1:0] != 0.

## Operation
- **Reset (rst=0, immediate):**
  - PC=`RESET_PC`, state FETCH_RUN, pending redirect cleared.
  - `instruction`=0, `instructionPC`=0, `instructionValid`=0, `misalignedFault`=0.
- **States:** FETCH_RUN, FETCH_FAULT.
- **FETCH_RUN, each edge, first matching rule wins:**
  1. `flush`=1:
     - `instructionValid`<=0.
     - PC<=`redirectTarget` if `redirectValid`, else the pending target if one is held, else PC unchanged (refetch).
     - Pending redirect cleared.
  2. `stall`=1:
     - IF/ID and PC hold.
     - If `redirectValid`, store `redirectTarget` as pending (a newer redirect overwrites an older one).
  3. Otherwise:
     - `instruction`<=`pcDataOutput`, `instructionPC`<=PC, `instructionValid`<=1.
     - PC<=`redirectTarget` if `redirectValid`, else the pending target, else PC+4.
     - Pending redirect cleared.
- **Delay slot:** the instruction latched on the same edge a redirect is applied (rule 3) is the delay slot and stays valid. Redirects never squash it; only `flush` does.
- **Arithmetic:** PC+4 is a 32-bit modulo add, so 32'hFFFFFFFC wraps to 32'h0. No carry out.
- **Misaligned target:** checked when a target is applied to PC (rules 1 and 3), not when it is stored as pending.
  - If target[1:0] != 0, PC holds its old value.
  - Next state is FETCH_FAULT and `misalignedFault`<=1.
  - In rule 3 the delay-slot latch on that edge still occurs.
- **FETCH_FAULT:**
  - `instructionValid`<=0 on every edge; PC frozen.
  - `stall`, `flush` and redirects are ignored.
  - Exit only via reset.

## Timing
- `pcAddress` equals the PC register with zero combinational logic. `Memory` returns `pcDataOutput` within the same cycle.
- Fetch latency is 1 edge: the word at `pcAddress` in cycle N appears on `instruction` after edge N.
- Throughput is 1 instruction per cycle when `stall`=0.
- Redirect applied on edge N: the target's instruction is on `instruction` after edge N+1. The delay slot is on `instruction` after edge N.
- A redirect that arrives while `stall`=1 is never lost. It takes effect on the first non-stalled edge, or on a flush edge.
- Reset deasserted mid-stream: the first edge after release fetches from `RESET_PC`.

## Structure
- Shared package `FetchPackage`:
  - `FetchState_t` enum {FETCH_RUN, FETCH_FAULT}.
  - `INSTRUCTION_BYTES`=4.
- No sub-module: one PC register, a next-PC priority mux, the pending-redirect register and the IF/ID register.
- Instantiated next to `Memory`, with `pcAddress` and `pcDataOutput` connected by name.

## Test plan
- **Sequential fetch:** preload `Memory` with words 0,1,2,3,4 at addresses 0,4,8,12,16. Release reset. Expect `instruction`=0,1,2,3,4 on successive edges, `instructionPC`=0..16, `instructionValid`=1 from the first edge.
- **Stall:** assert `stall` for 3 cycles at PC=8. Expect `pcAddress` to stay at 8 and `instruction` to stay at 1. Fetch resumes with 2 after `stall` drops.
- **Redirect with delay slot:** at PC=4 pulse `redirectValid` with target 16. Expect `instruction` sequence 1 then 4, with `instructionPC` 4 then 16.
- **Redirect during stall:** pulse a redirect to 12 while `stall`=1, then redirect to 0 while still stalled, then release. Expect the next PC to be 0 (the latest redirect wins) and nothing dropped.
- **Flush with redirect:** expect `instructionValid`=0 after the edge and PC=target.
- **Misaligned target:** redirect to 32'h6. Expect `misalignedFault`=1, `instructionValid`=0 thereafter, `pcAddress` frozen. Assert `rst`=0 and expect all outputs to clear.
- **Wrap:** `RESET_PC`=32'hFFFFFFFC; expect `pcAddress`=0 after the first edge.
